// File: rtl/config_master.sv
// config_master: host-side initiator for the chip configuration protocol.
// Builds one parity-protected packet per host command, hands it to the TX
// UART, and for reads waits for the matching reply (or a timeout) on the RX
// UART. Unsolicited or corrupt RX packets are counted in a saturating counter.
module config_master #(
    parameter int          WIDTH          = 64,
    parameter logic [7:0]  GLOBAL_ID      = 8'd255,
    parameter logic [31:0] MAGIC_NUMBER   = 32'h89504E47,
    parameter logic [1:0]  WRITE_OP       = 2'b10,
    parameter logic [1:0]  READ_OP        = 2'b11,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic             clk,
    input  logic             reset,
    // host command
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_read,
    input  logic [7:0]       cmd_chip_id,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_data,
    // TX UART
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    // RX UART
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_data_flag,
    // host response
    output logic             rsp_valid,
    output logic             rsp_timeout,
    output logic [7:0]       rsp_data,
    output logic [7:0]       rsp_chip_id,
    output logic [15:0]      drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TX_START,
        S_TX_DRAIN,
        S_WAIT_REPLY,
        S_DONE
    } state_t;

    // Last timer value before the reply wait gives up.
    localparam logic [15:0] TIMEOUT_LAST  = TIMEOUT_CYCLES - 16'd1;
    // TX_START gives the UART 16 cycles to raise tx_busy before moving on.
    localparam logic [15:0] TX_START_LAST = 16'd15;

    // Odd-parity command packet; unused upper bits stay zero.
    function automatic logic [WIDTH-1:0] build_packet(
        input logic       rd,
        input logic [7:0] chip,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        logic [WIDTH-1:0] p;
        p          = '0;
        p[1:0]     = rd ? READ_OP : WRITE_OP;
        p[9:2]     = chip;
        p[17:10]   = addr;
        p[25:18]   = rd ? 8'h00 : data;
        p[57:26]   = MAGIC_NUMBER;
        p[WIDTH-1] = ~^p[WIDTH-2:0];
        return p;
    endfunction

    // A packet is an acceptable reply to the outstanding read when parity,
    // reply flag, opcode, magic, address and (unless broadcast) chip all match.
    function automatic logic is_reply(
        input logic [WIDTH-1:0] p,
        input logic [7:0]       chip,
        input logic [7:0]       addr
    );
        logic ok;
        ok = (^p == 1'b1)
          && p[WIDTH-2]
          && (p[1:0] == READ_OP)
          && (p[17:10] == addr)
          && (p[57:26] == MAGIC_NUMBER)
          && ((chip == GLOBAL_ID) || (p[9:2] == chip));
        return ok;
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state_q,       state_d;
    logic             cmd_ready_q,   cmd_ready_d;
    logic [WIDTH-1:0] tx_data_q,     tx_data_d;
    logic             ld_q,          ld_d;
    logic             rsp_valid_q,   rsp_valid_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [7:0]       rsp_data_q,    rsp_data_d;
    logic [7:0]       rsp_chip_q,    rsp_chip_d;
    logic [15:0]      drop_q,        drop_d;
    logic [15:0]      timer_q,       timer_d;
    logic             read_q,        read_d;
    logic [7:0]       chip_q,        chip_d;
    logic [7:0]       addr_q,        addr_d;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_flag_q;
    logic             rx_prev_q;

    logic             rx_evt;
    logic             reply_hit;

    // Register the RX UART inputs and keep the previous flag for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q <= '0;
            rx_flag_q <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_data_q <= rx_data;
            rx_flag_q <= rx_data_flag;
            rx_prev_q <= rx_flag_q;
        end
    end

    // Each RX packet is evaluated once, on the rising edge of its flag.
    always_comb begin
        rx_evt    = rx_flag_q && !rx_prev_q;
        reply_hit = rx_evt && (state_q == S_WAIT_REPLY)
                 && is_reply(rx_data_q, chip_q, addr_q);
    end

    // Next-state and output computation for the command sequencer.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        ld_d          = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        rsp_data_d    = rsp_data_q;
        rsp_chip_d    = rsp_chip_q;
        timer_d       = timer_q;
        read_d        = read_q;
        chip_d        = chip_q;
        addr_d        = addr_q;
        drop_d        = drop_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    read_d    = cmd_read;
                    chip_d    = cmd_chip_id;
                    addr_d    = cmd_addr;
                    tx_data_d = build_packet(cmd_read, cmd_chip_id, cmd_addr, cmd_data);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!tx_busy) begin
                    ld_d    = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_TX_START;
                end
            end
            S_TX_START: begin
                // Do not hang if the UART never reports busy.
                if (tx_busy || (timer_q == TX_START_LAST)) begin
                    state_d = S_TX_DRAIN;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_TX_DRAIN: begin
                if (!tx_busy) begin
                    if (read_q) begin
                        timer_d = 16'd0;
                        state_d = S_WAIT_REPLY;
                    end else begin
                        rsp_timeout_d = 1'b0;
                        rsp_data_d    = 8'h00;
                        rsp_chip_d    = chip_q;
                        state_d       = S_DONE;
                    end
                end
            end
            S_WAIT_REPLY: begin
                // A reply arriving on the expiry cycle still wins.
                if (reply_hit) begin
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = rx_data_q[25:18];
                    rsp_chip_d    = rx_data_q[9:2];
                    state_d       = S_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = 8'h00;
                    rsp_chip_d    = chip_q;
                    state_d       = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Anything evaluated that is not the awaited reply is a drop.
        if (rx_evt && !reply_hit) begin
            drop_d = sat_inc16(drop_q);
        end

        // Registered handshake outputs track the state being entered.
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    // Sequencer state, latched command and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            tx_data_q     <= '0;
            ld_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_chip_q    <= 8'h00;
            drop_q        <= 16'h0000;
            timer_q       <= 16'h0000;
            read_q        <= 1'b0;
            chip_q        <= 8'h00;
            addr_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            tx_data_q     <= tx_data_d;
            ld_q          <= ld_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
            rsp_chip_q    <= rsp_chip_d;
            drop_q        <= drop_d;
            timer_q       <= timer_d;
            read_q        <= read_d;
            chip_q        <= chip_d;
            addr_q        <= addr_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign tx_data     = tx_data_q;
    assign ld_tx_data  = ld_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_chip_id = rsp_chip_q;
    assign drop_count  = drop_q;

endmodule
